// File: rtl/vga_pkg.sv
// Shared VGA frame constants, coordinate widths and the IDLE/CLEAR state
// encoding used by the plot arbiter and the pixel sources around it.
package vga_pkg;

    localparam int WIDTH  = 160;
    localparam int HEIGHT = 120;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int C_W    = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_t;

    // True when (x, y) lies inside a w-by-h frame.
    function automatic logic in_frame(input logic [X_W-1:0] x,
                                      input logic [Y_W-1:0] y,
                                      input int w,
                                      input int h);
        return (int'(x) < w) && (int'(y) < h);
    endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Bundle of the arbiter's pixel-source handshakes, clear control and the
// VGA adapter write port. master = sources / top level, slave = arbiter.
interface vga_plot_arbiter_if;
    import vga_pkg::*;

    logic           clear_start;
    logic           clear_busy;
    logic           clear_done;

    logic           snake_req;
    logic [X_W-1:0] snake_x;
    logic [Y_W-1:0] snake_y;
    logic [C_W-1:0] snake_colour;
    logic           snake_gnt;

    logic           ovl_req;
    logic [X_W-1:0] ovl_x;
    logic [Y_W-1:0] ovl_y;
    logic [C_W-1:0] ovl_colour;
    logic           ovl_gnt;

    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;
    logic           plot;
    logic           oob_flag;

    modport master (
        output clear_start,
        output snake_req, snake_x, snake_y, snake_colour,
        output ovl_req, ovl_x, ovl_y, ovl_colour,
        input  clear_busy, clear_done, snake_gnt, ovl_gnt,
        input  x_out, y_out, colour_out, plot, oob_flag
    );

    modport slave (
        input  clear_start,
        input  snake_req, snake_x, snake_y, snake_colour,
        input  ovl_req, ovl_x, ovl_y, ovl_colour,
        output clear_busy, clear_done, snake_gnt, ovl_gnt,
        output x_out, y_out, colour_out, plot, oob_flag
    );

endinterface

// File: rtl/vga_plot_arbiter_clear_scanner.sv
// Row-major x/y scan counter for the full-frame clear. Presents the current
// scan coordinate while busy, flags the final pixel, and pulses done one
// cycle later so it lines up with that pixel leaving the output register.
module clear_scanner
    import vga_pkg::*;
#(
    parameter int WIDTH  = vga_pkg::WIDTH,
    parameter int HEIGHT = vga_pkg::HEIGHT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_busy,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last,
    output logic           o_done
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    logic [X_W-1:0] r_x, w_x_next;
    logic [Y_W-1:0] r_y, w_y_next;
    logic           r_done;
    logic           w_last;

    assign w_last = i_busy && (r_x == X_LAST) && (r_y == Y_LAST);

    // Next scan position: x wraps at the frame edge (not at 255), y steps per row.
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        if (i_start || w_last) begin
            w_x_next = '0;
            w_y_next = '0;
        end else if (i_busy) begin
            if (r_x == X_LAST) begin
                w_x_next = '0;
                w_y_next = r_y + 1'b1;
            end else begin
                w_x_next = r_x + 1'b1;
            end
        end
    end

    // Counter and done-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_x    <= w_x_next;
            r_y    <= w_y_next;
            r_done <= w_last;
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_last;
    assign o_done = r_done;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter write port between the snake datapath, the score
// overlay and an internal full-frame clear engine. Grants are combinational
// from the current requests; the winning pixel is registered onto the port.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int             WIDTH        = vga_pkg::WIDTH,
    parameter int             HEIGHT       = vga_pkg::HEIGHT,
    parameter logic [C_W-1:0] CLEAR_COLOUR = 3'b000,
    parameter int             MAX_STREAK   = 8
) (
    input  logic              clk,
    input  logic              rst,
    vga_plot_arbiter_if.slave bus
);

    localparam int             SW       = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_STREAK);

    arb_state_t     r_state, w_state_next;
    logic [SW-1:0]  r_streak, w_streak_next;

    logic [X_W-1:0] r_x, w_x_next;
    logic [Y_W-1:0] r_y, w_y_next;
    logic [C_W-1:0] r_colour, w_colour_next;
    logic           r_plot, w_plot_next;
    logic           r_oob, w_oob_next;

    logic           w_idle;
    logic           w_streak_full;
    logic           w_snake_gnt;
    logic           w_ovl_gnt;
    logic [X_W-1:0] w_scan_x;
    logic [Y_W-1:0] w_scan_y;
    logic           w_scan_last;
    logic           w_scan_done;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_streak_full = (r_streak == STREAK_MAX);

    // Snake has priority unless it has starved a waiting overlay for MAX_STREAK grants.
    assign w_snake_gnt = w_idle && bus.snake_req && !(bus.ovl_req && w_streak_full);
    assign w_ovl_gnt   = w_idle && bus.ovl_req && !w_snake_gnt;

    clear_scanner #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_scanner (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_idle && bus.clear_start),
        .i_busy  (!w_idle),
        .o_x     (w_scan_x),
        .o_y     (w_scan_y),
        .o_last  (w_scan_last),
        .o_done  (w_scan_done)
    );

    // FSM next state: clear requests only take effect from IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.clear_start) w_state_next = ST_CLEAR;
            ST_CLEAR: if (w_scan_last)     w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Streak counts snake wins while the overlay waits; any overlay win or idle overlay resets it.
    always_comb begin
        w_streak_next = r_streak;
        if (w_ovl_gnt || !bus.ovl_req) begin
            w_streak_next = '0;
        end else if (w_snake_gnt && !w_streak_full) begin
            w_streak_next = r_streak + 1'b1;
        end
    end

    // Output pixel selection; out-of-frame grants raise the sticky flag instead of plotting.
    always_comb begin
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_colour_next = r_colour;
        w_plot_next   = 1'b0;
        w_oob_next    = r_oob;
        if (!w_idle) begin
            w_x_next      = w_scan_x;
            w_y_next      = w_scan_y;
            w_colour_next = CLEAR_COLOUR;
            w_plot_next   = 1'b1;
        end else if (w_snake_gnt) begin
            if (in_frame(bus.snake_x, bus.snake_y, WIDTH, HEIGHT)) begin
                w_x_next      = bus.snake_x;
                w_y_next      = bus.snake_y;
                w_colour_next = bus.snake_colour;
                w_plot_next   = 1'b1;
            end else begin
                w_oob_next = 1'b1;
            end
        end else if (w_ovl_gnt) begin
            if (in_frame(bus.ovl_x, bus.ovl_y, WIDTH, HEIGHT)) begin
                w_x_next      = bus.ovl_x;
                w_y_next      = bus.ovl_y;
                w_colour_next = bus.ovl_colour;
                w_plot_next   = 1'b1;
            end else begin
                w_oob_next = 1'b1;
            end
        end
    end

    // State, streak and output-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_oob    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
            r_x      <= w_x_next;
            r_y      <= w_y_next;
            r_colour <= w_colour_next;
            r_plot   <= w_plot_next;
            r_oob    <= w_oob_next;
        end
    end

    assign bus.snake_gnt  = w_snake_gnt;
    assign bus.ovl_gnt    = w_ovl_gnt;
    assign bus.clear_busy = !w_idle;
    assign bus.clear_done = w_scan_done;
    assign bus.x_out      = r_x;
    assign bus.y_out      = r_y;
    assign bus.colour_out = r_colour;
    assign bus.plot       = r_plot;
    assign bus.oob_flag   = r_oob;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, single requester, contention,
// out-of-frame, full clear with a late second pulse, and reset mid-clear.
module tb_vga_plot_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    vga_plot_arbiter_if bus ();

    vga_plot_arbiter #(
        .WIDTH        (160),
        .HEIGHT       (120),
        .CLEAR_COLOUR (3'b000),
        .MAX_STREAK   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int  plots;
        int  bad_col;
        int  done_cnt;
        int  gnt_cnt;
        int  gnt_at_done;
        int  first_x, first_y, last_x, last_y;
        bit  finished;
        bit  exp_ovl;

        n_vec  = 0;
        n_fail = 0;

        rst              = 1'b1;
        bus.clear_start  = 1'b0;
        bus.snake_req    = 1'b0;
        bus.snake_x      = '0;
        bus.snake_y      = '0;
        bus.snake_colour = '0;
        bus.ovl_req      = 1'b0;
        bus.ovl_x        = '0;
        bus.ovl_y        = '0;
        bus.ovl_colour   = '0;

        // ---- reset state ----
        repeat (2) tick();
        rst = 1'b0;
        check("rst_x_out",      bus.x_out,      0);
        check("rst_y_out",      bus.y_out,      0);
        check("rst_colour",     bus.colour_out, 0);
        check("rst_plot",       bus.plot,       0);
        check("rst_busy",       bus.clear_busy, 0);
        check("rst_done",       bus.clear_done, 0);
        check("rst_oob",        bus.oob_flag,   0);
        tick();
        tick();

        // ---- single requester ----
        bus.snake_req = 1'b1; bus.snake_x = 8'd10; bus.snake_y = 7'd20; bus.snake_colour = 3'b010;
        #1;
        check("single_snake_gnt", bus.snake_gnt, 1);
        check("single_ovl_gnt",   bus.ovl_gnt,   0);
        tick();
        bus.snake_req = 1'b0;
        check("single_x",      bus.x_out,      10);
        check("single_y",      bus.y_out,      20);
        check("single_colour", bus.colour_out, 3'b010);
        check("single_plot",   bus.plot,       1);
        tick();
        check("single_plot_off", bus.plot,  0);
        check("single_x_hold",   bus.x_out, 10);

        // ---- contention: 8 snake, 1 overlay, repeating ----
        bus.snake_req = 1'b1; bus.snake_x = 8'd1; bus.snake_y = 7'd1; bus.snake_colour = 3'd1;
        bus.ovl_req   = 1'b1; bus.ovl_x   = 8'd2; bus.ovl_y   = 7'd2; bus.ovl_colour   = 3'd4;
        for (int i = 0; i < 20; i++) begin
            exp_ovl = ((i % 9) == 8);
            #1;
            check($sformatf("cont_snake_gnt_%0d", i), bus.snake_gnt, {31'd0, !exp_ovl});
            check($sformatf("cont_ovl_gnt_%0d", i),   bus.ovl_gnt,   {31'd0, exp_ovl});
            tick();
            check($sformatf("cont_colour_%0d", i), bus.colour_out, exp_ovl ? 4 : 1);
            check($sformatf("cont_plot_%0d", i),   bus.plot,       1);
        end
        bus.snake_req = 1'b0;
        bus.ovl_req   = 1'b0;
        tick();

        // ---- boundary in-frame pixel (159,119) ----
        bus.ovl_req = 1'b1; bus.ovl_x = 8'd159; bus.ovl_y = 7'd119; bus.ovl_colour = 3'd6;
        #1;
        check("edge_ovl_gnt", bus.ovl_gnt, 1);
        tick();
        bus.ovl_req = 1'b0;
        check("edge_plot", bus.plot,  1);
        check("edge_x",    bus.x_out, 159);
        check("edge_y",    bus.y_out, 119);
        check("edge_oob",  bus.oob_flag, 0);

        // ---- out-of-frame pixels ----
        bus.snake_req = 1'b1; bus.snake_x = 8'd5; bus.snake_y = 7'd120; bus.snake_colour = 3'd3;
        #1;
        check("oob_y_gnt", bus.snake_gnt, 1);
        tick();
        bus.snake_req = 1'b0;
        check("oob_y_plot", bus.plot,     0);
        check("oob_y_flag", bus.oob_flag, 1);
        bus.ovl_req = 1'b1; bus.ovl_x = 8'd160; bus.ovl_y = 7'd5; bus.ovl_colour = 3'd7;
        #1;
        check("oob_x_gnt", bus.ovl_gnt, 1);
        tick();
        bus.ovl_req = 1'b0;
        check("oob_x_plot", bus.plot,     0);
        check("oob_x_flag", bus.oob_flag, 1);
        repeat (3) tick();
        check("oob_sticky", bus.oob_flag, 1);

        // ---- full clear, snake held, clear_start in the same cycle as a snake request ----
        bus.clear_start = 1'b1;
        bus.snake_req = 1'b1; bus.snake_x = 8'd30; bus.snake_y = 7'd40; bus.snake_colour = 3'd5;
        #1;
        check("same_cycle_snake_gnt", bus.snake_gnt, 1);
        tick();
        bus.clear_start = 1'b0;
        bus.snake_x = 8'd50; bus.snake_y = 7'd60; bus.snake_colour = 3'd6;
        check("same_cycle_x",    bus.x_out,      30);
        check("same_cycle_busy", bus.clear_busy, 1);
        #1;
        check("clear_no_gnt_first", bus.snake_gnt, 0);

        plots = 0; bad_col = 0; done_cnt = 0; gnt_cnt = 0; gnt_at_done = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; finished = 1'b0;
        for (int c = 0; c < 19300 && !finished; c++) begin
            tick();
            if (bus.plot) begin
                if (plots == 0) begin
                    first_x = int'(bus.x_out);
                    first_y = int'(bus.y_out);
                end
                last_x = int'(bus.x_out);
                last_y = int'(bus.y_out);
                if (bus.colour_out != 3'd0) bad_col++;
                plots++;
            end
            bus.clear_start = (plots == 100);
            #1;
            if (bus.clear_done) done_cnt++;
            if (bus.snake_gnt) begin
                gnt_cnt++;
                if (bus.clear_done) gnt_at_done++;
                finished = 1'b1;
            end
        end
        bus.clear_start = 1'b0;
        check("clear_finished",     {31'd0, finished}, 1);
        check("clear_plot_count",   plots,       19200);
        check("clear_first_x",      first_x,     0);
        check("clear_first_y",      first_y,     0);
        check("clear_last_x",       last_x,      159);
        check("clear_last_y",       last_y,      119);
        check("clear_bad_colour",   bad_col,     0);
        check("clear_done_count",   done_cnt,    1);
        check("clear_snake_gnts",   gnt_cnt,     1);
        check("clear_gnt_at_done",  gnt_at_done, 1);
        tick();
        bus.snake_req = 1'b0;
        check("post_clear_x",    bus.x_out,      50);
        check("post_clear_plot", bus.plot,       1);
        check("post_clear_busy", bus.clear_busy, 0);
        tick();
        check("post_clear_idle_plot", bus.plot,       0);
        check("post_clear_idle_done", bus.clear_done, 0);
        check("oob_survives_clear",   bus.oob_flag,   1);

        // ---- reset mid-clear ----
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        plots = 0;
        done_cnt = 0;
        for (int c = 0; c < 5100 && plots < 5000; c++) begin
            tick();
            if (bus.plot) plots++;
            if (bus.clear_done) done_cnt++;
        end
        check("mid_plot_count", plots,          5000);
        check("mid_busy",       bus.clear_busy, 1);
        check("mid_x",          bus.x_out,      4999 % 160);
        check("mid_y",          bus.y_out,      4999 / 160);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_plot",   bus.plot,       0);
        check("abort_busy",   bus.clear_busy, 0);
        check("abort_x",      bus.x_out,      0);
        check("abort_y",      bus.y_out,      0);
        check("abort_oob",    bus.oob_flag,   0);
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.clear_done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // ---- restart after abort ----
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("restart_busy",      bus.clear_busy, 1);
        check("restart_plot_wait", bus.plot,       0);
        tick();
        check("restart_plot0", bus.plot,  1);
        check("restart_x0",    bus.x_out, 0);
        check("restart_y0",    bus.y_out, 0);
        tick();
        check("restart_x1",    bus.x_out, 1);
        check("restart_y1",    bus.y_out, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_busy", bus.clear_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
